// File: rtl/spike_addr_tx_pkg.sv
// Shared definitions for the spike address transmitter.
//   ADDR_W      : default source-address width
//   IDLE_ADDR   : address driven when no spike is being sent (matches no MAC entry)
//   NUM_NEURONS : default count of local neurons
//   state_e     : transmitter FSM encoding
package spike_addr_tx_pkg;
    localparam int                ADDR_W      = 12;
    localparam logic [ADDR_W-1:0] IDLE_ADDR   = 12'hFFF;
    localparam int                NUM_NEURONS = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_END  = 2'd2
    } state_e;
endpackage

// File: rtl/spike_addr_tx_lsb_prio_enc.sv
// Lowest-set-bit priority encoder (purely combinational).
//   vec_i : input bit vector
//   idx_o : index of the lowest set bit (0 when vec_i is zero)
//   nz_o  : vec_i has at least one bit set
module lsb_prio_enc #(
    parameter int W     = 10,
    parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]     vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             nz_o
);
    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
    end

    assign nz_o = |vec_i;
endmodule

// File: rtl/spike_addr_tx.sv
// Serialises one timestep of neuron spikes into a stream of source addresses
// (base + neuron index, lowest index first), then pulses timestep_end.
//   CLK, RST       : clock, synchronous active-high reset
//   spikes_in      : per-neuron spike flags, valid with spikes_valid
//   spikes_valid   : one-cycle strobe, also samples base_address
//   base_address   : address of neuron 0
//   source_address : outgoing address (IDLE_ADDR when addr_valid=0)
//   addr_valid     : source_address carries a spike
//   addr_ready     : downstream accepts the address this cycle
//   timestep_end   : one-cycle end-of-timestep pulse (MAC clear)
//   busy           : transmitter not idle
//   overrun        : sticky, a strobe arrived while busy and was dropped
module spike_addr_tx #(
    parameter int                NUM_NEURONS = spike_addr_tx_pkg::NUM_NEURONS,
    parameter int                ADDR_W      = spike_addr_tx_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] IDLE_ADDR   = spike_addr_tx_pkg::IDLE_ADDR
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_NEURONS-1:0] spikes_in,
    input  logic                   spikes_valid,
    input  logic [ADDR_W-1:0]      base_address,
    output logic [ADDR_W-1:0]      source_address,
    output logic                   addr_valid,
    input  logic                   addr_ready,
    output logic                   timestep_end,
    output logic                   busy,
    output logic                   overrun
);
    import spike_addr_tx_pkg::*;

    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    state_e                 state_q, state_d;
    logic [NUM_NEURONS-1:0] pend_q, pend_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic                   ovr_q, ovr_d;

    logic [IDX_W-1:0]       idx;
    logic                   pend_nz;
    logic [NUM_NEURONS-1:0] pend_clr;

    lsb_prio_enc #(
        .W     (NUM_NEURONS),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec_i (pend_q),
        .idx_o (idx),
        .nz_o  (pend_nz)
    );

    // Pending set with the currently offered bit removed.
    assign pend_clr = pend_q & ~(NUM_NEURONS'(1) << idx);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            base_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            base_q  <= base_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        base_d         = base_q;
        ovr_d          = ovr_q;
        addr_valid     = 1'b0;
        source_address = IDLE_ADDR;
        timestep_end   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (spikes_valid) begin
                    pend_d  = spikes_in;
                    base_d  = base_address;
                    state_d = (|spikes_in) ? ST_SEND : ST_END;
                end
            end
            ST_SEND: begin
                // pend_q is never empty here; pend_nz only guards the output.
                addr_valid = pend_nz;
                if (pend_nz) source_address = base_q + ADDR_W'(idx); // wraps mod 2^ADDR_W
                if (spikes_valid) ovr_d = 1'b1;
                if (pend_nz && addr_ready) begin
                    pend_d = pend_clr;
                    if (pend_clr == '0) state_d = ST_END;
                end
            end
            ST_END: begin
                timestep_end = 1'b1;
                if (spikes_valid) ovr_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign overrun = ovr_q;
endmodule

// File: tb/tb_spike_addr_tx.sv
module tb_spike_addr_tx;
    logic        CLK = 1'b0;
    logic        RST;
    logic [9:0]  spikes_in;
    logic        spikes_valid;
    logic [11:0] base_address;
    logic [11:0] source_address;
    logic        addr_valid;
    logic        addr_ready;
    logic        timestep_end;
    logic        busy;
    logic        overrun;

    spike_addr_tx dut (
        .CLK            (CLK),
        .RST            (RST),
        .spikes_in      (spikes_in),
        .spikes_valid   (spikes_valid),
        .base_address   (base_address),
        .source_address (source_address),
        .addr_valid     (addr_valid),
        .addr_ready     (addr_ready),
        .timestep_end   (timestep_end),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 CLK = ~CLK;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          t0     = 0;
    int          te_cnt = 0;
    logic [11:0] exp_q[$];
    bit          prev_stall = 1'b0;
    logic [11:0] prev_addr  = '0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Scoreboard monitor: every handshake pops one expected address.
    always @(negedge CLK) begin
        if (RST) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(addr_valid), 32'd1);
                chk("hold_addr", 32'(source_address), 32'(prev_addr));
            end
            if (!addr_valid) chk("idle_addr", 32'(source_address), 32'hFFF);
            if (addr_valid && addr_ready) begin
                if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
                else chk("addr", 32'(source_address), 32'(exp_q.pop_front()));
            end
            if (timestep_end) te_cnt++;
            prev_stall = addr_valid && !addr_ready;
            prev_addr  = source_address;
        end
    end

    // Drive a one-cycle strobe; t0 is the cycle right after the capture edge.
    task automatic send_strobe(input logic [9:0] spk, input logic [11:0] base, input bit push);
        logic [11:0] a;
        @(posedge CLK); #1;
        spikes_in    = spk;
        base_address = base;
        spikes_valid = 1'b1;
        if (push) begin
            for (int i = 0; i < 10; i++) begin
                if (spk[i]) begin
                    a = base + 12'(i);
                    exp_q.push_back(a);
                end
            end
        end
        @(posedge CLK); #1;
        t0           = cyc;
        spikes_valid = 1'b0;
        spikes_in    = '0;
    endtask

    // Latency is counted in cycles from the strobe cycle (strobe = cycle t).
    task automatic wait_te(output int lat, output int bcyc);
        lat  = -1;
        bcyc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (busy) bcyc++;
            if (timestep_end) begin
                lat = cyc - t0 + 1;
                break;
            end
        end
    endtask

    int lat, bcyc, te_before;

    initial begin
        RST          = 1'b1;
        spikes_valid = 1'b1;          // must be ignored during reset
        spikes_in    = 10'h3FF;
        base_address = 12'h123;
        addr_ready   = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_valid", 32'(addr_valid), 32'd0);
        chk("rst_te", 32'(timestep_end), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_addr", 32'(source_address), 32'hFFF);
        @(posedge CLK); #1;
        RST          = 1'b0;
        spikes_valid = 1'b0;
        spikes_in    = '0;
        @(negedge CLK);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Basic send: 3, 4, 7 then timestep_end, busy 4 cycles.
        send_strobe(10'b0000010011, 12'd3, 1'b1);
        @(negedge CLK);
        chk("first_valid_lat", 32'(addr_valid), 32'd1);
        wait_te(lat, bcyc);
        chk("basic_te_lat", 32'(lat), 32'd4);
        chk("basic_busy", 32'(bcyc + 1), 32'd4);   // +1 for the cycle consumed above
        chk("basic_sb", 32'(exp_q.size()), 32'd0);
        @(negedge CLK);
        chk("basic_idle", 32'(busy), 32'd0);

        // Stall: address 0 held 4 cycles, then 9, then timestep_end.
        addr_ready = 1'b0;
        send_strobe(10'b1000000001, 12'd0, 1'b1);
        repeat (3) @(posedge CLK);
        #1 addr_ready = 1'b1;
        wait_te(lat, bcyc);
        chk("stall_te_lat", 32'(lat), 32'd6);
        chk("stall_sb", 32'(exp_q.size()), 32'd0);

        // Empty timestep.
        send_strobe(10'b0, 12'd50, 1'b1);
        wait_te(lat, bcyc);
        chk("empty_te_lat", 32'(lat), 32'd1);
        chk("empty_busy", 32'(bcyc), 32'd1);

        // Wrap-around of base + index.
        send_strobe(10'b0000001100, 12'hFFE, 1'b1);
        wait_te(lat, bcyc);
        chk("wrap_te_lat", 32'(lat), 32'd3);
        chk("wrap_sb", 32'(exp_q.size()), 32'd0);

        // Overrun: second strobe during SEND is dropped.
        chk("pre_ovr", 32'(overrun), 32'd0);
        send_strobe(10'b0000010011, 12'd100, 1'b1);
        spikes_valid = 1'b1;
        spikes_in    = 10'h3FF;
        base_address = 12'd0;
        @(posedge CLK); #1;
        spikes_valid = 1'b0;
        spikes_in    = '0;
        @(negedge CLK);
        chk("ovr_set", 32'(overrun), 32'd1);
        wait_te(lat, bcyc);
        chk("ovr_te_lat", 32'(lat), 32'd4);
        chk("ovr_sb", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge CLK);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        chk("ovr_idle", 32'(busy), 32'd0);

        // Reset mid-SEND after the first address.
        send_strobe(10'b0000000111, 12'd20, 1'b1);
        @(posedge CLK); #1;
        RST        = 1'b1;
        addr_ready = 1'b0;
        te_before  = te_cnt;
        @(posedge CLK); #1;
        RST        = 1'b0;
        addr_ready = 1'b1;
        chk("rst_mid_popped", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        @(negedge CLK);
        chk("rst_mid_valid", 32'(addr_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_te", 32'(timestep_end), 32'd0);
        chk("rst_mid_ovr", 32'(overrun), 32'd0);
        repeat (3) @(negedge CLK);
        chk("rst_mid_no_te", 32'(te_cnt), 32'(te_before));

        // New strobe after abort is accepted normally.
        send_strobe(10'b0100000010, 12'd7, 1'b1);
        wait_te(lat, bcyc);
        chk("after_rst_te_lat", 32'(lat), 32'd3);
        chk("after_rst_sb", 32'(exp_q.size()), 32'd0);

        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule

// File: doc/spike_addr_tx.md
SPIKE_ADDR_TX -- requirements
Module: spike_addr_tx

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of CLK.
REQ-002 Parameter NUM_NEURONS, default 10: number of local neurons whose spikes are serialised.
REQ-003 Parameter ADDR_W, default 12: source-address width.
REQ-004 Parameter IDLE_ADDR, default 12'hFFF: address driven while no address is valid; it SHALL match no MAC connection entry.
REQ-005 Port: CLK, input, 1, system clock.
REQ-006 Port: RST, input, 1, synchronous active-high reset.
REQ-007 Port: spikes_in, input, NUM_NEURONS, per-neuron spike flags for the finished timestep; bit i = neuron i.
REQ-008 Port: spikes_valid, input, 1, one-cycle strobe; spikes_in is valid in that cycle.
REQ-009 Port: base_address, input, ADDR_W, address of neuron 0; sampled together with spikes_in.
REQ-010 Port: source_address, output, ADDR_W, spike source address toward the MAC units.
REQ-011 Port: addr_valid, output, 1, source_address carries a spike.
REQ-012 Port: addr_ready, input, 1, downstream accepts the address this cycle.
REQ-013 Port: timestep_end, output, 1, one-cycle pulse marking the end of the timestep; this is the MAC clear.
REQ-014 Port: busy, output, 1, high in every state except IDLE.
REQ-015 Port: overrun, output, 1, sticky flag set when a strobe is dropped.

Function
REQ-016 The FSM SHALL have three states: IDLE, SEND and END.
REQ-017 IDLE with spikes_valid=1 SHALL capture spikes_in into the pending register and base_address into the base register.
REQ-018 From that IDLE capture, the FSM SHALL go to SEND if spikes_in is nonzero, else to END.
REQ-019 In SEND, addr_valid SHALL be 1 and source_address SHALL equal base + i, where i is the lowest set pending bit.
REQ-020 The sum base + i SHALL be computed modulo 2^ADDR_W; wrap-around is legal (base 12'hFFE, i=3 gives 12'h001).
REQ-021 A handshake is addr_valid=1 and addr_ready=1 in the same cycle; it SHALL clear pending bit i.
REQ-022 source_address and addr_valid SHALL hold stable while addr_ready=0.
REQ-023 SEND SHALL go to END on the handshake that clears the last pending bit.
REQ-024 Each handshake SHALL issue at most one address.
REQ-025 END SHALL last exactly one cycle with timestep_end=1, addr_valid=0 and source_address=IDLE_ADDR, then go to IDLE.
REQ-026 Latency: strobe in cycle t gives the first addr_valid in cycle t+1.
REQ-027 Latency: with addr_ready held at 1 and k spikes, timestep_end SHALL occur in cycle t+k+1.
REQ-028 Latency: an all-zero strobe in cycle t gives timestep_end in cycle t+1.
REQ-029 spikes_valid in SEND or END SHALL be ignored and SHALL set overrun; the transfer in progress SHALL be unaffected.
REQ-030 overrun SHALL clear only on reset.
REQ-031 When addr_valid=0, source_address SHALL equal IDLE_ADDR.
REQ-032 Bits of spikes_in at or above NUM_NEURONS do not exist; the pending register SHALL be exactly NUM_NEURONS wide.

Reset
REQ-033 When RST=1 at a clock edge, the state SHALL become IDLE and the pending and base registers SHALL become 0.
REQ-034 Reset output values SHALL be: addr_valid=0, timestep_end=0, busy=0, overrun=0, source_address=IDLE_ADDR.
REQ-035 Reset during SEND or END SHALL abort the timestep without emitting timestep_end.
REQ-036 spikes_valid in the reset cycle SHALL be ignored.

Structure
REQ-037 A shared package SHALL hold ADDR_W, IDLE_ADDR, the state encoding (IDLE=2'd0, SEND=2'd1, END=2'd2) and the default NUM_NEURONS.
REQ-038 The lowest-set-bit priority encoder SHALL be a separate sub-module, lsb_prio_enc, which outputs the index and a nonzero flag.
REQ-039 The priority encoder SHALL be purely combinational; all registers SHALL live in spike_addr_tx.

Verification
REQ-040 Basic send: spikes_in=10'b0000010011, base=12'd3, addr_ready=1 -> addresses 3, 4, 7 on consecutive cycles, then timestep_end; busy for 4 cycles.
REQ-041 Stall: spikes_in=10'b1000000001, base=0, addr_ready low for 3 cycles -> address 0 held for 4 cycles; then address 9; then timestep_end.
REQ-042 Empty timestep: spikes_in=0 -> no addr_valid; timestep_end exactly 1 cycle after the strobe; source_address stays 12'hFFF.
REQ-043 Wrap: base=12'hFFE, spikes_in=10'b0000001100 -> addresses 12'h000, 12'h001.
REQ-044 Overrun: second strobe during SEND -> overrun=1 and remains 1; the original address sequence completes unchanged.
REQ-045 Reset mid-SEND: RST after the first address -> next cycle addr_valid=0, busy=0, no timestep_end; a new strobe is accepted normally.
